// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite interconnect: arbiter FSM states and requester-count bounds.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_OFFER  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_t;

    localparam int N_REQ_MIN = 2;
    localparam int N_REQ_MAX = 16;

endpackage

// File: rtl/prio_enc_n.sv
// Rotating priority encoder: first set request found searching downward from i_start, wrapping at 0.
module prio_enc_n #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx,
    output logic [N-1:0]     o_onehot
);

    logic [2*N-1:0] w_dbl;

    // The doubled vector lays the wrapped search order out contiguously: masking everything
    // above N+start leaves the highest surviving bit as the first hit of the descending search.
    always_comb begin
        w_dbl = {i_req, i_req};
        for (int j = 0; j < 2*N; j++) begin
            if (j > N + int'(i_start)) begin
                w_dbl[j] = 1'b0;
            end
        end
        o_idx = '0;
        for (int j = 0; j < 2*N; j++) begin
            if (w_dbl[j]) begin
                o_idx = (j >= N) ? IDX_W'(j - N) : IDX_W'(j);
            end
        end
    end

    assign o_found  = |i_req;
    assign o_onehot = o_found ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// N-way request arbiter with valid/ready offer and release-terminated grant lock.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise the highest index wins. `release` is a
// reserved word, so the transaction-end pulse is named gnt_release.
module axi_lite_rr_arbiter
    import axi_lite_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic [N_REQ-1:0] req,
    output logic             gnt_valid,
    input  logic             gnt_ready,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic             busy,
    input  logic             gnt_release
);

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(N_REQ - 1);

    arb_state_t       r_state;
    logic             r_gnt_valid;
    logic             r_busy;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [N_REQ-1:0] r_gnt_onehot;

    logic             w_found;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_start;
    logic [N_REQ-1:0] w_onehot;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_ptr;
    assign w_start = r_ptr;
`else
    assign w_start = TOP_IDX;
`endif

    prio_enc_n #(.N(N_REQ)) u_prio_enc (
        .i_req    (req),
        .i_start  (w_start),
        .o_found  (w_found),
        .o_idx    (w_idx),
        .o_onehot (w_onehot)
    );

    // The winner is captured once in IDLE and frozen until release, so req changes never withdraw an offer.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state      <= ARB_IDLE;
            r_gnt_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_gnt_idx    <= '0;
            r_gnt_onehot <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr        <= TOP_IDX;
`endif
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_gnt_idx    <= w_idx;
                        r_gnt_onehot <= w_onehot;
                        r_gnt_valid  <= 1'b1;
                        r_state      <= ARB_OFFER;
                    end
                end
                ARB_OFFER: begin
                    if (gnt_ready) begin
                        r_gnt_valid <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (gnt_release) begin
                        r_busy       <= 1'b0;
                        r_gnt_onehot <= '0;
                        r_state      <= ARB_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                        r_ptr        <= (r_gnt_idx == '0) ? TOP_IDX : r_gnt_idx - 1'b1;
`endif
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign gnt_valid  = r_gnt_valid;
    assign gnt_idx    = r_gnt_idx;
    assign gnt_onehot = r_gnt_onehot;
    assign busy       = r_busy;

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Bench for axi_lite_rr_arbiter: 4-way and 8-way instances against a phase/queue-free reference model.
module tb_axi_lite_rr_arbiter;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] reqv [2];
    logic [1:0]  rdy  = '0;
    logic [1:0]  rel  = '0;
    logic [1:0]  a_valid, a_busy;
    logic [1:0]  idx4;
    logic [2:0]  idx8;
    logic [3:0]  oh4;
    logic [7:0]  oh8;
    logic [15:0] a_idx [2];
    logic [15:0] a_oh  [2];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int m_phase [2];   // 0 = nothing offered, 1 = offered, 2 = accepted
    int m_idx   [2];
    int m_ptr   [2];

    always #5 clk = ~clk;

    assign a_idx[0] = 16'(idx4);
    assign a_idx[1] = 16'(idx8);
    assign a_oh[0]  = 16'(oh4);
    assign a_oh[1]  = 16'(oh8);

    axi_lite_rr_arbiter #(.N_REQ(4)) u_d4 (
        .ACLK(clk), .ARESETN(rstn), .req(reqv[0][3:0]),
        .gnt_valid(a_valid[0]), .gnt_ready(rdy[0]), .gnt_idx(idx4),
        .gnt_onehot(oh4), .busy(a_busy[0]), .gnt_release(rel[0])
    );

    axi_lite_rr_arbiter #(.N_REQ(8)) u_d8 (
        .ACLK(clk), .ARESETN(rstn), .req(reqv[1][7:0]),
        .gnt_valid(a_valid[1]), .gnt_ready(rdy[1]), .gnt_idx(idx8),
        .gnt_onehot(oh8), .busy(a_busy[1]), .gnt_release(rel[1])
    );

    function automatic int nof(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    // Walk ptr, ptr-1, ... modulo n; -1 when nothing is requesting.
    function automatic int pick(input logic [15:0] r, input int n, input int ptr);
        for (int k = 0; k < n; k++) begin
            if (r[(ptr - k + n) % n]) return (ptr - k + n) % n;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int d = 0; d < 2; d++) begin
                m_phase[d] <= 0;
                m_idx[d]   <= 0;
                m_ptr[d]   <= nof(d) - 1;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                case (m_phase[d])
                    0: if (pick(reqv[d], nof(d), m_ptr[d]) >= 0) begin
                        m_idx[d]   <= pick(reqv[d], nof(d), m_ptr[d]);
                        m_phase[d] <= 1;
                    end
                    1: if (rdy[d]) m_phase[d] <= 2;
                    default: if (rel[d]) begin
                        m_phase[d] <= 0;
`ifdef ARB_ROUND_ROBIN_EN
                        m_ptr[d]   <= (m_idx[d] + nof(d) - 1) % nof(d);
`endif
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("valid", d, 16'(a_valid[d]), 16'(m_phase[d] == 1));
                chk("busy", d, 16'(a_busy[d]), 16'(m_phase[d] == 2));
                chk("idx", d, a_idx[d], 16'(m_idx[d]));
                chk("onehot", d, a_oh[d], (m_phase[d] != 0) ? (16'd1 << m_idx[d]) : 16'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        reqv[0] = '0; reqv[1] = '0; rdy = '0; rel = '0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic wait_valid(input int d);
        for (int i = 0; i < 20; i++) begin
            if (a_valid[d]) return;
            tick();
        end
        chk("wait_valid_timeout", d, 16'(a_valid[d]), 16'd1);
    endtask

    task automatic grant_once(input int d, output int w);
        wait_valid(d);
        w = int'(a_idx[d]);
        rdy[d] = 1'b1; tick(); rdy[d] = 1'b0;
        rel[d] = 1'b1; tick(); rel[d] = 1'b0;
    endtask

    int w;
    int rr_exp [5];

    initial begin
        reqv[0] = '0; reqv[1] = '0;
        #1;
        chk("rst_valid", 0, 16'(a_valid[0]), 16'd0);
        chk("rst_busy", 0, 16'(a_busy[0]), 16'd0);
        chk("rst_idx", 1, a_idx[1], 16'd0);
        do_reset();
        chk_en = 1'b1;

        // Fixed first arbitration, stable offer while req changes, handshake latency
        reqv[0] = 16'h6; tick();
        chk("first_valid", 0, 16'(a_valid[0]), 16'd1);
        chk("first_idx", 0, a_idx[0], 16'd2);
        chk("first_oh", 0, a_oh[0], 16'h4);
        reqv[0] = 16'h8;
        repeat (5) begin
            tick();
            chk("hold_idx", 0, a_idx[0], 16'd2);
        end
        reqv[0] = 16'hF;
        rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
        chk("acc_busy", 0, 16'(a_busy[0]), 16'd1);
        chk("acc_valid", 0, 16'(a_valid[0]), 16'd0);
        rel[0] = 1'b1; tick(); rel[0] = 1'b0;
        chk("rel_busy", 0, 16'(a_busy[0]), 16'd0);
        chk("rel_valid", 0, 16'(a_valid[0]), 16'd0);
        chk("rel_oh", 0, a_oh[0], 16'd0);
        tick();
        chk("regrant_valid", 0, 16'(a_valid[0]), 16'd1);
`ifdef ARB_ROUND_ROBIN_EN
        chk("regrant_idx", 0, a_idx[0], 16'd1);
`else
        chk("regrant_idx", 0, a_idx[0], 16'd3);
`endif
        rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
        rel[0] = 1'b1; reqv[0] = '0; tick(); rel[0] = 1'b0;
        repeat (4) begin
            rdy = 2'b11; rel = 2'b11; tick();
            chk("spur_valid", 0, 16'(a_valid[0]), 16'd0);
            chk("spur_busy", 0, 16'(a_busy[0]), 16'd0);
        end
        rdy = '0; rel = '0;

        // Asynchronous reset while locked
        do_reset();
        reqv[0] = 16'h1; tick();
        rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
        chk("lock_busy", 0, 16'(a_busy[0]), 16'd1);
        #1 rstn = 1'b0;
        #1;
        chk("arst_busy", 0, 16'(a_busy[0]), 16'd0);
        chk("arst_valid", 0, 16'(a_valid[0]), 16'd0);
        chk("arst_oh", 0, a_oh[0], 16'd0);
        chk("arst_idx", 0, a_idx[0], 16'd0);
        reqv[0] = '0;
        tick(); tick();
        rstn = 1'b1;
        repeat (3) begin
            tick();
            chk("post_rst_valid", 0, 16'(a_valid[0]), 16'd0);
        end

        // Rotation fairness with all masters requesting
        do_reset();
`ifdef ARB_ROUND_ROBIN_EN
        rr_exp = '{3, 2, 1, 0, 3};
`else
        rr_exp = '{3, 3, 3, 3, 3};
`endif
        reqv[0] = 16'hF;
        for (int k = 0; k < 5; k++) begin
            grant_once(0, w);
            chk("rr_seq", 0, 16'(w), 16'(rr_exp[k]));
        end
        reqv[0] = '0;

        // Wrap on the 8-way instance
        do_reset();
        reqv[1] = 16'h01;
        grant_once(1, w);
        chk("wrap_first", 1, 16'(w), 16'd0);
        reqv[1] = 16'h81;
        grant_once(1, w);
        chk("wrap_second", 1, 16'(w), 16'd7);
        grant_once(1, w);
`ifdef ARB_ROUND_ROBIN_EN
        chk("wrap_third", 1, 16'(w), 16'd0);
`else
        chk("wrap_third", 1, 16'(w), 16'd7);
`endif
        reqv[1] = '0;

        // Winning request drops while offered
        do_reset();
        reqv[0] = 16'h1; tick();
        reqv[0] = '0;
        repeat (3) begin
            tick();
            chk("drop_valid", 0, 16'(a_valid[0]), 16'd1);
            chk("drop_idx", 0, a_idx[0], 16'd0);
        end
        rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
        chk("drop_busy", 0, 16'(a_busy[0]), 16'd1);
        rel[0] = 1'b1; tick(); rel[0] = 1'b0;
        repeat (2) begin
            tick();
            chk("drop_idle", 0, 16'(a_valid[0]), 16'd0);
        end

        // Randomized traffic on both instances, checked by the model every cycle
        do_reset();
        repeat (3000) begin
            reqv[0] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 15));
            reqv[1] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 255));
            rdy = 2'($urandom);
            rel = 2'($urandom);
            tick();
        end
        rdy = '0; rel = '0;
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_rr_arbiter.md
# axi_lite_rr_arbiter

Parametrised N-way request arbiter for the AXI4-Lite interconnect, successor to the fixed 4-to-2 priority encoder. Samples N_REQ request lines, selects one winner by fixed or rotating priority, and offers it downstream through a valid/ready handshake. Once accepted, the grant is locked until the owning transaction signals release. Sits in front of the shared AXI4-Lite slave port, selecting which master drives AW/W/AR.

## Interface
- N_REQ, 4, number of requesters (2..16)
- IDX_W, $clog2(N_REQ), derived localparam, width of encoded index
- ACLK  in  1  clock, all logic on rising edge
- ARESETN  in  1  asynchronous active-low reset
- req  in  N_REQ  level request per master; bit i = master i
- gnt_valid  out  1  winner offered downstream
- gnt_ready  in  1  downstream accepts offered winner
- gnt_idx  out  IDX_W  encoded winner index
- gnt_onehot  out  N_REQ  one-hot winner; zero when no grant is offered or locked
- busy  out  1  grant accepted and locked
- release  in  1  single-cycle pulse ending the locked transaction

## Operation
- FSM states: IDLE, OFFER, LOCKED.
- IDLE: if req != 0, register winner into gnt_idx/gnt_onehot, assert gnt_valid, go to OFFER. If req == 0, stay; gnt_idx holds its last value.
- OFFER: gnt_valid=1. gnt_idx/gnt_onehot stay stable regardless of req changes (no withdrawal, even if the winning req drops). On gnt_ready=1: drop gnt_valid, assert busy, go to LOCKED.
- LOCKED: busy=1, gnt_onehot holds. On release=1: clear busy and gnt_onehot, update the priority pointer, go to IDLE.
- release outside LOCKED is ignored. gnt_ready outside OFFER is ignored.
- Winner selection in fixed mode: highest set index wins (req=4'b1010 selects 3).
- Winner selection in round-robin mode: search starts at index ptr and descends with wrap (ptr, ptr-1, ..., 0, N_REQ-1, ...). First set bit wins.
- Pointer update: on release of winner w, ptr <= (w == 0) ? N_REQ-1 : w-1. This makes w the lowest priority next time.
- Reset value of ptr is N_REQ-1, so the first arbitration matches fixed mode.
- Reset (asynchronous, any state): state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0, busy=0, ptr=N_REQ-1. An in-flight grant is discarded with no release required.

## Timing
- Request sampled in IDLE at edge k: gnt_valid=1 from edge k+1.
- gnt_valid and gnt_ready both high at edge m: busy=1 and gnt_valid=0 from edge m+1.
- release at edge r: busy=0 from r+1, IDLE during cycle r+1. The earliest next gnt_valid is r+2.
- Minimum back-to-back grant period is 3 cycles (IDLE, OFFER with immediate ready, LOCKED with immediate release).
- All outputs are registered. There is no combinational path from req, gnt_ready or release to any output.

## Configuration
- ARB_ROUND_ROBIN_EN defined: rotating priority as above, ptr register present.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, highest index wins. ptr is removed and pointer updates are no-ops. Behaviour is otherwise identical, including the FSM and the handshake.

## Structure
- Shared package axi_lite_pkg holds the state enum (ARB_IDLE, ARB_OFFER, ARB_LOCKED) and the N_REQ bounds constants.
- Sub-module prio_enc_n: combinational, parameter N. Takes req and start pointer; returns found, index and one-hot. Rotation is done via double-width masking. It is instantiated once.
- The top level contains the FSM, output registers and ptr.

## Test plan
- Reset mid-LOCKED with N_REQ=4: ARESETN low while busy=1 -> all outputs 0 immediately, state IDLE; after deassert with req=0, gnt_valid stays 0.
- Fixed priority: req=4'b0110 -> gnt_valid at next edge, gnt_idx=2, gnt_onehot=4'b0100. Hold gnt_ready=0 for 5 cycles while req changes to 4'b1000 -> gnt_idx stays 2.
- Handshake latency: ready asserted in the OFFER cycle, release one cycle later -> next gnt_valid exactly 2 cycles after release. Spurious release/gnt_ready in IDLE causes no state change.
- Round-robin fairness (ARB_ROUND_ROBIN_EN, N_REQ=4): req=4'b1111 held, immediate ready/release -> grant sequence 3,2,1,0,3.
- Wrap case (N_REQ=8): grant 0 released, req=8'b1000_0001 -> next winner 7; then release -> next winner 0.
- Drop during OFFER: req=4'b0001 granted, req drops to 0 before gnt_ready -> offer held with gnt_idx=0 until accepted; completes normally, then IDLE with gnt_valid=0.
